alu_share_arbiter: RTL and testbench

Round-robin arbiter and two-stage issue pipeline that shares one combinational 32-bit ALU (operands a/b, 3-bit function f, outputs y/zero/OF) between NREQ requesters. Each requester presents a valid request with operands; the block grants one per cycle, drives the ALU from an issue register, and captures the ALU result into a response register tagged with the requester ID. Sits between the datapath clients and the ALU; the ALU itself is external.

---
 rtl/alu_share_arbiter_if.sv | 39 +++
 rtl/alu_share_arbiter.sv | 163 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Bundle between the datapath clients and the shared-ALU arbiter.
// slave: seen from the arbiter. master: seen from the clients and the ALU.
interface alu_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ*3-1:0] req_f;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      alu_a;
  logic [W-1:0]      alu_b;
  logic [2:0]        alu_f;
  logic [W-1:0]      alu_y;
  logic              alu_zero;
  logic              alu_of;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_y;
  logic              rsp_zero;
  logic              rsp_of;
  logic              ovf_flag;
  logic [IDW-1:0]    ovf_id;

  modport slave (
    input  req, req_f, req_a, req_b, alu_y, alu_zero, alu_of, rsp_ready,
    output gnt, alu_a, alu_b, alu_f, rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_of,
           ovf_flag, ovf_id
  );

  modport master (
    output req, req_f, req_a, req_b, alu_y, alu_zero, alu_of, rsp_ready,
    input  gnt, alu_a, alu_b, alu_f, rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_of,
           ovf_flag, ovf_id
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter plus issue/response pipeline sharing one external ALU
// among NREQ requesters. Optional sticky overflow trap: ALU_OVF_TRAP_EN.
module alu_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int IDW  = 2
) (
  input logic            clk,
  input logic            reset,
  alu_share_arbiter_if.slave bus
);
  // per-requester views of the flattened request buses
  logic [NREQ-1:0][W-1:0] lane_a, lane_b;
  logic [NREQ-1:0][2:0]   lane_f;
  assign lane_a = bus.req_a;
  assign lane_b = bus.req_b;
  assign lane_f = bus.req_f;

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           iss_valid_q, iss_valid_d;
  logic [W-1:0]   iss_a_q, iss_a_d, iss_b_q, iss_b_d;
  logic [2:0]     iss_f_q, iss_f_d;
  logic [IDW-1:0] iss_id_q, iss_id_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [W-1:0]   rsp_y_q, rsp_y_d;
  logic           rsp_zero_q, rsp_zero_d, rsp_of_q, rsp_of_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;

  logic           adv_rsp, adv_iss, found;
  logic [IDW-1:0] win, cand;
  logic [NREQ-1:0] gnt;

  assign adv_rsp = !rsp_valid_q || bus.rsp_ready;
  assign adv_iss = !iss_valid_q || adv_rsp;

  // pick the first requester at or after the pointer, wrapping; nothing when stalled
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    gnt   = '0;
    if (adv_iss) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = IDW'((int'(ptr_q) + k) % NREQ);
        if (!found && bus.req[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
    end
    if (found) gnt[win] = 1'b1;
  end

  assign bus.gnt = gnt;

  // pointer moves past the winner; issue register loads the winner's operands
  always_comb begin
    ptr_d       = ptr_q;
    iss_valid_d = iss_valid_q;
    iss_a_d     = iss_a_q;
    iss_b_d     = iss_b_q;
    iss_f_d     = iss_f_q;
    iss_id_d    = iss_id_q;
    if (adv_iss) begin
      iss_valid_d = found;
      if (found) begin
        ptr_d    = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
        iss_a_d  = lane_a[win];
        iss_b_d  = lane_b[win];
        iss_f_d  = lane_f[win];
        iss_id_d = win;
      end
    end
  end

  // response register captures the ALU output for the op in the issue register
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_y_d     = rsp_y_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_of_d    = rsp_of_q;
    rsp_id_d    = rsp_id_q;
    if (adv_rsp) begin
      rsp_valid_d = iss_valid_q;
      if (iss_valid_q) begin
        rsp_y_d    = bus.alu_y;
        rsp_zero_d = bus.alu_zero;
        rsp_of_d   = bus.alu_of;
        rsp_id_d   = iss_id_q;
      end
    end
  end

  // pipeline state; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      iss_valid_q <= 1'b0;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
      iss_f_q     <= '0;
      iss_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_of_q    <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      iss_valid_q <= iss_valid_d;
      iss_a_q     <= iss_a_d;
      iss_b_q     <= iss_b_d;
      iss_f_q     <= iss_f_d;
      iss_id_q    <= iss_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_of_q    <= rsp_of_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign bus.alu_a     = iss_a_q;
  assign bus.alu_b     = iss_b_q;
  assign bus.alu_f     = iss_f_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_of    = rsp_of_q;
  assign bus.rsp_id    = rsp_id_q;

`ifdef ALU_OVF_TRAP_EN
  logic           ovf_flag_q, ovf_flag_d;
  logic [IDW-1:0] ovf_id_q, ovf_id_d;

  // remember only the first overflowing result; later ones leave the ID alone
  always_comb begin
    ovf_flag_d = ovf_flag_q;
    ovf_id_d   = ovf_id_q;
    if (adv_rsp && iss_valid_q && bus.alu_of && !ovf_flag_q) begin
      ovf_flag_d = 1'b1;
      ovf_id_d   = iss_id_q;
    end
  end

  // sticky trap state, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_flag_q <= 1'b0;
      ovf_id_q   <= '0;
    end else begin
      ovf_flag_q <= ovf_flag_d;
      ovf_id_q   <= ovf_id_d;
    end
  end

  assign bus.ovf_flag = ovf_flag_q;
  assign bus.ovf_id   = ovf_id_q;
`else
  assign bus.ovf_flag = 1'b0;
  assign bus.ovf_id   = '0;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table, multi-cycle corner
// sequences, then random traffic against a queue-based reference model.
module tb_alu_share_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = 2;
`ifdef ALU_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus();
  alu_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {logic [31:0] y; logic z; logic o;} res_t;

  // external ALU: and/or/add/sub/slt, xor for the remaining codes
  function automatic res_t alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    res_t r;
    r.o = 1'b0;
    case (f)
      3'b000: r.y = a & b;
      3'b001: r.y = a | b;
      3'b010: begin r.y = a + b; r.o = (a[31] == b[31]) && (r.y[31] != a[31]); end
      3'b110: begin r.y = a - b; r.o = (a[31] != b[31]) && (r.y[31] != a[31]); end
      3'b111: r.y = {31'b0, $signed(a) < $signed(b)};
      default: r.y = a ^ b;
    endcase
    r.z = (r.y == 32'd0);
    return r;
  endfunction

  res_t alu_out;
  assign alu_out      = alu_ref(bus.alu_a, bus.alu_b, bus.alu_f);
  assign bus.alu_y    = alu_out.y;
  assign bus.alu_zero = alu_out.z;
  assign bus.alu_of   = alu_out.o;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    bus.req[id]           = 1'b1;
    bus.req_a[id*W +: W]  = a;
    bus.req_b[id*W +: W]  = b;
    bus.req_f[id*3 +: 3]  = f;
  endtask

  // one isolated op: grant this cycle, ALU driven next, response the one after
  task automatic do_op(input string tag, input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f, input logic [31:0] ey, input logic ez, input logic eo);
    set_op(id, a, b, f);
    #1;
    chk({tag, ".gnt"}, 64'(bus.gnt), 64'(1 << id));
    tick();
    bus.req = '0;
    chk({tag, ".alu_a"}, 64'(bus.alu_a), 64'(a));
    chk({tag, ".alu_b"}, 64'(bus.alu_b), 64'(b));
    chk({tag, ".alu_f"}, 64'(bus.alu_f), 64'(f));
    chk({tag, ".rv_early"}, 64'(bus.rsp_valid), 64'(0));
    tick();
    chk({tag, ".rv"}, 64'(bus.rsp_valid), 64'(1));
    chk({tag, ".y"}, 64'(bus.rsp_y), 64'(ey));
    chk({tag, ".zero"}, 64'(bus.rsp_zero), 64'(ez));
    chk({tag, ".of"}, 64'(bus.rsp_of), 64'(eo));
    chk({tag, ".id"}, 64'(bus.rsp_id), 64'(id));
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    int          id;
    logic [31:0] a, b;
    logic [2:0]  f;
    logic [31:0] ey;
    logic        ez, eo;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] a, b;
    logic [2:0]  f;
    bit          in_rsp;
  } ent_t;

  int eg_bp[8] = '{1, 2, 0, 0, 4, 0, 0, 0};
  int rv_bp[8] = '{0, 0, 1, 1, 1, 1, 1, 0};
  int id_bp[8] = '{0, 0, 0, 0, 0, 1, 2, 0};

  initial begin
    vec_t vt[7];
    ent_t q[$];
    int   ptr_m, w;
    logic [NREQ-1:0] g;
    res_t er;

    vt[0] = '{2, 32'd5, 32'd7, 3'b010, 32'd12, 1'b0, 1'b0};
    vt[1] = '{0, 32'd3, 32'd3, 3'b110, 32'd0, 1'b1, 1'b0};
    vt[2] = '{1, 32'h0000F0F0, 32'h00000FF0, 3'b000, 32'h000000F0, 1'b0, 1'b0};
    vt[3] = '{3, 32'd1, 32'd2, 3'b110, 32'hFFFFFFFF, 1'b0, 1'b0};
    vt[4] = '{2, 32'h7FFFFFFF, 32'd1, 3'b010, 32'h80000000, 1'b0, 1'b1};
    vt[5] = '{1, 32'h80000000, 32'd1, 3'b110, 32'h7FFFFFFF, 1'b0, 1'b1};
    vt[6] = '{0, 32'h00000000, 32'h00000000, 3'b010, 32'd0, 1'b1, 1'b0};

    bus.req = '0; bus.req_a = '0; bus.req_b = '0; bus.req_f = '0;
    bus.rsp_ready = 1'b1;
    do_reset();

    // reset state
    chk("rst.rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst.rsp_y", 64'(bus.rsp_y), 64'(0));
    chk("rst.rsp_id", 64'(bus.rsp_id), 64'(0));
    chk("rst.rsp_flags", 64'({bus.rsp_zero, bus.rsp_of}), 64'(0));
    chk("rst.alu", 64'({bus.alu_f, bus.alu_a | bus.alu_b}), 64'(0));
    chk("rst.ovf", 64'({bus.ovf_flag, bus.ovf_id}), 64'(0));
    chk("rst.gnt", 64'(bus.gnt), 64'(0));

    // overflow trap: first overflow from requester 1 sticks, requester 3 does not replace it
    do_op("ovf1", 1, 32'h7FFFFFFF, 32'd1, 3'b010, 32'h80000000, 1'b0, 1'b1);
    chk("ovf1.flag", 64'(bus.ovf_flag), 64'(TRAP));
    chk("ovf1.id", 64'(bus.ovf_id), TRAP ? 64'(1) : 64'(0));
    do_op("ovf3", 3, 32'h80000000, 32'hFFFFFFFF, 3'b010, 32'h7FFFFFFF, 1'b0, 1'b1);
    chk("ovf3.flag", 64'(bus.ovf_flag), 64'(TRAP));
    chk("ovf3.id", 64'(bus.ovf_id), TRAP ? 64'(1) : 64'(0));

    // vector table
    for (int i = 0; i < 7; i++)
      do_op($sformatf("vec%0d", i), vt[i].id, vt[i].a, vt[i].b, vt[i].f, vt[i].ey, vt[i].ez, vt[i].eo);
    chk("vec.ovf_id_kept", 64'(bus.ovf_id), TRAP ? 64'(1) : 64'(0));

    // all four requesting continuously: 0,1,2,3,0,... one response per cycle
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(i * 10), 32'd1, 3'b010);
    for (int c = 0; c < 10; c++) begin
      if (c == 8) bus.req = '0;
      #1;
      if (c < 8) chk($sformatf("rr.gnt%0d", c), 64'(bus.gnt), 64'(1 << (c % 4)));
      if (c >= 2) begin
        chk($sformatf("rr.rv%0d", c), 64'(bus.rsp_valid), 64'(1));
        chk($sformatf("rr.id%0d", c), 64'(bus.rsp_id), 64'((c - 2) % 4));
        chk($sformatf("rr.y%0d", c), 64'(bus.rsp_y), 64'(((c - 2) % 4) * 10 + 1));
      end
      tick();
    end
    chk("rr.drained", 64'(bus.rsp_valid), 64'(0));

    // backpressure: two accepted while stalled, third issues after release
    for (int i = 0; i < 3; i++) set_op(i, 32'(100 + i), 32'(i), 3'b010);
    for (int c = 0; c < 8; c++) begin
      bus.rsp_ready = (c >= 4);
      #1;
      chk($sformatf("bp.gnt%0d", c), 64'(bus.gnt), 64'(eg_bp[c]));
      chk($sformatf("bp.rv%0d", c), 64'(bus.rsp_valid), 64'(rv_bp[c]));
      if (rv_bp[c] != 0) begin
        chk($sformatf("bp.id%0d", c), 64'(bus.rsp_id), 64'(id_bp[c]));
        chk($sformatf("bp.y%0d", c), 64'(bus.rsp_y), 64'(100 + 2 * id_bp[c]));
      end
      g = bus.gnt;
      tick();
      bus.req = bus.req & ~g;
    end

    // reset with both stages full: nothing from them may emerge, pointer back to 0
    bus.rsp_ready = 1'b0;
    set_op(1, 32'd55, 32'd1, 3'b010);
    set_op(3, 32'd77, 32'd1, 3'b010);
    for (int c = 0; c < 2; c++) begin
      g = bus.gnt;
      tick();
      bus.req = bus.req & ~g;
    end
    #1;
    chk("rm.full_rv", 64'(bus.rsp_valid), 64'(1));
    chk("rm.full_gnt", 64'(bus.gnt), 64'(0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req = '0;
    bus.rsp_ready = 1'b1;
    #1;
    chk("rm.rv0", 64'(bus.rsp_valid), 64'(0));
    chk("rm.alu_a", 64'(bus.alu_a), 64'(0));
    tick();
    chk("rm.rv1", 64'(bus.rsp_valid), 64'(0));
    set_op(0, 32'd9, 32'd9, 3'b110);
    set_op(3, 32'd9, 32'd9, 3'b110);
    #1;
    chk("rm.first_gnt", 64'(bus.gnt), 64'(1));

    // random traffic against the queue model
    do_reset();
    q.delete();
    ptr_m = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NREQ; i++)
        if (!bus.req[i] && $urandom_range(0, 1) == 1)
          set_op(i,
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                 3'($urandom_range(0, 7)));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      w = -1;
      if (q.size() < 2 || bus.rsp_ready)
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && bus.req[(ptr_m + k) % NREQ]) w = (ptr_m + k) % NREQ;
      chk("rnd.gnt", 64'(bus.gnt), (w >= 0) ? 64'(1 << w) : 64'(0));
      chk("rnd.rv", 64'(bus.rsp_valid), 64'(q.size() > 0 && q[0].in_rsp));
      if (q.size() > 0 && q[0].in_rsp) begin
        er = alu_ref(q[0].a, q[0].b, q[0].f);
        chk("rnd.id", 64'(bus.rsp_id), 64'(q[0].id));
        chk("rnd.y", 64'(bus.rsp_y), 64'(er.y));
        chk("rnd.flags", 64'({bus.rsp_zero, bus.rsp_of}), 64'({er.z, er.o}));
      end
      if (q.size() > 0 && !q[q.size()-1].in_rsp)
        chk("rnd.alu", {29'b0, bus.alu_f, bus.alu_a}, {29'b0, q[q.size()-1].f, q[q.size()-1].a});
      tick();
      if (q.size() > 0 && q[0].in_rsp && bus.rsp_ready) void'(q.pop_front());
      if (q.size() > 0 && !q[0].in_rsp) q[0].in_rsp = 1'b1;
      if (w >= 0) begin
        q.push_back('{w, bus.req_a[w*W +: W], bus.req_b[w*W +: W], bus.req_f[w*3 +: 3], 1'b0});
        bus.req[w] = 1'b0;
        ptr_m = (w + 1) % NREQ;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
